// File: rtl/iob_xfer_engine_pkg.sv
// Shared command modes, FSM states and helpers for the IOb transfer engine.
package iob_xfer_engine_pkg;

    localparam logic [1:0] MODE_R = 2'd0;
    localparam logic [1:0] MODE_W = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RD,
        ST_RSP
    } state_t;

    // Number of bytes touched by an access of the given bit width.
    function automatic int unsigned bytes_of(input int unsigned bits);
        return (bits + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/iob_xfer_engine_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued commands.
module iob_xfer_engine_fifo #(
    parameter int unsigned W          = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic         clk,
    input  logic         cke,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [W-1:0]        mem [0:DEPTH-1];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    // The extra pointer MSB tells full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (cke) begin
            if (push && !full)
                wr_ptr <= wr_ptr + (DEPTH_LOG2 + 1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (cke && push && !full)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/iob_xfer_engine.sv
// IOb native bus master: queues byte-addressed read/write commands, aligns them to
// DATA_W-wide bus words and returns one in-order response per command.
module iob_xfer_engine #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned CMD_DEPTH_LOG2 = 2,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [1:0]               cmd_mode_i,
    input  logic [ADDR_W-1:0]        cmd_addr_i,
    input  logic [$clog2(DATA_W):0]  cmd_width_i,
    input  logic [DATA_W-1:0]        cmd_data_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic                     rsp_err_o,
    output logic                     iob_valid_o,
    output logic [ADDR_W-1:0]        iob_addr_o,
    output logic [DATA_W-1:0]        iob_wdata_o,
    output logic [DATA_W/8-1:0]      iob_wstrb_o,
    input  logic                     iob_ready_i,
    input  logic                     iob_rvalid_i,
    input  logic [DATA_W-1:0]        iob_rdata_i,
    output logic                     busy_o
);

    import iob_xfer_engine_pkg::*;

    localparam int unsigned W_W    = $clog2(DATA_W) + 1;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned CMD_W  = 2 + ADDR_W + W_W + DATA_W;
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [CMD_W-1:0]     fifo_out;
    logic [1:0]           c_mode;
    logic [ADDR_W-1:0]    c_addr;
    logic [W_W-1:0]       c_width;
    logic [DATA_W-1:0]    c_data;
    logic [OFF_W-1:0]     c_off;
    int unsigned          c_nbytes;
    logic                 c_err;
    logic [STRB_W-1:0]    c_strb;
    logic                 is_read;
    logic [OFF_W-1:0]     off_r;
    logic [W_W-1:0]       width_r;
    logic [DATA_W-1:0]    rd_mask;
    logic [DATA_W-1:0]    rd_data;
    logic [TIMEOUT_W-1:0] tmo_cnt;

    assign cmd_ready_o = !fifo_full;
    assign fifo_pop    = (state == ST_IDLE) && !fifo_empty && !rsp_valid_o;
    assign busy_o      = !fifo_empty || (state != ST_IDLE) || rsp_valid_o;

    iob_xfer_engine_fifo #(
        .W          (CMD_W),
        .DEPTH_LOG2 (CMD_DEPTH_LOG2)
    ) u_cmd_fifo (
        .clk       (clk_i),
        .cke       (cke_i),
        .rst       (rst_i),
        .push      (cmd_valid_i && cmd_ready_o),
        .push_data ({cmd_mode_i, cmd_addr_i, cmd_width_i, cmd_data_i}),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Decode of the command at the FIFO head, consumed in the cycle it is popped.
    assign {c_mode, c_addr, c_width, c_data} = fifo_out;
    assign c_off    = c_addr[OFF_W-1:0];
    assign c_nbytes = bytes_of(32'(c_width));
    assign c_err    = (c_mode > MODE_W) || (c_width == '0) ||
                      (c_width > W_W'(DATA_W)) || ((32'(c_off) + c_nbytes) > STRB_W);

    always_comb begin
        c_strb = '0;
        if (c_mode == MODE_W) begin
            if (c_nbytes >= STRB_W)
                c_strb = '1;
            else
                c_strb = STRB_W'((STRB_W'(1) << c_nbytes) - STRB_W'(1));
            c_strb = c_strb << c_off;
        end
    end

    assign rd_mask = (32'(width_r) >= DATA_W) ? '1 :
                     DATA_W'((DATA_W'(1) << width_r) - DATA_W'(1));
    assign rd_data = (iob_rdata_i >> {off_r, 3'b000}) & rd_mask;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            iob_valid_o <= 1'b0;
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
            iob_wstrb_o <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            is_read     <= 1'b0;
            off_r       <= '0;
            width_r     <= '0;
            tmo_cnt     <= '0;
        end else if (cke_i) begin
            unique case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        if (c_err) begin
                            state       <= ST_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_data_o  <= '0;
                        end else begin
                            state       <= ST_REQ;
                            iob_valid_o <= 1'b1;
                            iob_addr_o  <= {c_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            iob_wdata_o <= c_data << {c_off, 3'b000};
                            iob_wstrb_o <= c_strb;
                            is_read     <= (c_mode == MODE_R);
                            off_r       <= c_off;
                            width_r     <= c_width;
                            tmo_cnt     <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (iob_ready_i) begin
                        iob_valid_o <= 1'b0;
                        if (!is_read || iob_rvalid_i) begin
                            state       <= ST_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_data_o  <= is_read ? rd_data : '0;
                        end else begin
                            state   <= ST_WAIT_RD;
                            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= ST_RSP;
                        iob_valid_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_data_o  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                    end
                end
                ST_WAIT_RD: begin
                    if (iob_rvalid_i) begin
                        state       <= ST_RSP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_data_o  <= rd_data;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= ST_RSP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_data_o  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        state       <= ST_IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_data_o  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_xfer_engine.sv
// Directed and randomized bench for iob_xfer_engine against a byte-lane reference model.
module tb_iob_xfer_engine;

    logic        clk_i;
    logic        cke_i;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_mode_i;
    logic [31:0] cmd_addr_i;
    logic [5:0]  cmd_width_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        iob_valid_o;
    logic [31:0] iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_ready_i;
    logic        iob_rvalid_i;
    logic [31:0] iob_rdata_i;
    logic        busy_o;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [1:0]  m;
    logic [31:0] a;
    logic [31:0] d;
    int          w;
    int          n;
    bit          e_err;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rsp;
    logic [3:0]  e_strb;
    logic [32:0] exp_q[$];
    logic [32:0] exp_rsp;

    localparam logic [31:0] QRDATA = 32'hC3A5_5A3C;

    iob_xfer_engine #(
        .DATA_W         (32),
        .ADDR_W         (32),
        .CMD_DEPTH_LOG2 (2),
        .TIMEOUT_W      (4)
    ) dut (
        .clk_i        (clk_i),
        .cke_i        (cke_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_mode_i   (cmd_mode_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_width_i  (cmd_width_i),
        .cmd_data_i   (cmd_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .iob_valid_o  (iob_valid_o),
        .iob_addr_o   (iob_addr_o),
        .iob_wdata_o  (iob_wdata_o),
        .iob_wstrb_o  (iob_wstrb_o),
        .iob_ready_i  (iob_ready_i),
        .iob_rvalid_i (iob_rvalid_i),
        .iob_rdata_i  (iob_rdata_i),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed hang, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Reference: which byte lanes a command touches and what comes back.
    function automatic void model(input logic [1:0] mode, input logic [31:0] addr, input int width,
                                  input logic [31:0] data, input logic [31:0] rdata,
                                  output bit err, output logic [31:0] eaddr, output logic [3:0] estrb,
                                  output logic [31:0] ewdata, output logic [31:0] ersp);
        int off = int'(addr % 4);
        int nbytes = (width + 7) / 8;
        logic [63:0] wide = {32'b0, data} << (8 * off);
        err    = (mode > 1) || (width == 0) || (width > 32) || (off + nbytes > 4);
        eaddr  = addr - 32'(off);
        ewdata = wide[31:0];
        estrb  = '0;
        for (int b = 0; b < 4; b++)
            if (mode == 1 && b >= off && b < off + nbytes) estrb[b] = 1'b1;
        ersp = '0;
        if (!err && mode == 0)
            for (int i = 0; i < width; i++) ersp[i] = rdata[8 * off + i];
    endfunction

    task automatic rand_cmd(output logic [1:0] mode, output logic [31:0] addr,
                            output int width, output logic [31:0] data);
        int r = $urandom_range(0, 9);
        mode  = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : 2'(2 + (r % 2));
        addr  = $urandom;
        width = $urandom_range(0, 34);
        data  = $urandom;
    endtask

    // One command through an idle engine; rdly cycles before ready, rvdly cycles ready->rvalid.
    task automatic xfer(input logic [1:0] mode, input logic [31:0] addr, input int width,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input int rdly, input int rvdly);
        bit x_err;
        logic [31:0] x_addr, x_wdata, x_rsp;
        logic [3:0] x_strb;
        model(mode, addr, width, data, rdata, x_err, x_addr, x_strb, x_wdata, x_rsp);
        check("cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_mode_i  = mode;
        cmd_addr_i  = addr;
        cmd_width_i = 6'(width);
        cmd_data_i  = data;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        if (x_err) begin
            check("err_no_bus", iob_valid_o, 0);
            check("err_rsp_valid", rsp_valid_o, 1);
        end else begin
            check("req", {iob_valid_o, iob_addr_o, iob_wstrb_o, iob_wdata_o},
                  {1'b1, x_addr, x_strb, x_wdata});
            for (int i = 0; i < rdly; i++) begin
                @(negedge clk_i);
                check("req_hold", {iob_valid_o, iob_addr_o, iob_wstrb_o, iob_wdata_o},
                      {1'b1, x_addr, x_strb, x_wdata});
            end
            iob_ready_i = 1'b1;
            if (mode == 0 && rvdly == 0) begin
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = rdata;
            end
            @(negedge clk_i);
            iob_ready_i  = 1'b0;
            iob_rvalid_i = 1'b0;
            iob_rdata_i  = $urandom;
            check("req_drop", iob_valid_o, 0);
            if (mode == 0 && rvdly > 0) begin
                for (int j = 1; j < rvdly; j++) begin
                    check("wait_rd", rsp_valid_o, 0);
                    @(negedge clk_i);
                end
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = rdata;
                @(negedge clk_i);
                iob_rvalid_i = 1'b0;
                iob_rdata_i  = $urandom;
            end
            check("rsp_valid", rsp_valid_o, 1);
        end
        check("rsp", {rsp_err_o, rsp_data_o}, {x_err, x_rsp});
        @(negedge clk_i);
        check("rsp_hold", {rsp_valid_o, rsp_err_o, rsp_data_o}, {1'b1, x_err, x_rsp});
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check("rsp_done", {rsp_valid_o, busy_o}, 0);
    endtask

    initial begin
        rst_i        = 1'b1;
        cke_i        = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_mode_i   = '0;
        cmd_addr_i   = '0;
        cmd_width_i  = '0;
        cmd_data_i   = '0;
        rsp_ready_i  = 1'b0;
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        iob_rdata_i  = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_ctrl", {iob_valid_o, rsp_valid_o, rsp_err_o, busy_o}, 0);
        check("rst_data", {iob_addr_o, iob_wdata_o, iob_wstrb_o, rsp_data_o}, 0);

        // Directed alignment and error cases.
        xfer(2'd1, 32'h06, 16, 32'h0000_BEEF, 32'h0, 0, 0);
        xfer(2'd0, 32'h05, 8, 32'h0, 32'h0000_AB00, 0, 2);
        xfer(2'd1, 32'h03, 16, 32'h1234, 32'h0, 0, 0);
        xfer(2'd2, 32'h08, 8, 32'h55, 32'h0, 0, 0);
        xfer(2'd3, 32'h0C, 32, 32'h55, 32'h0, 0, 0);
        xfer(2'd0, 32'h04, 0, 32'h0, 32'hFFFF_FFFF, 0, 0);
        xfer(2'd1, 32'h00, 33, 32'h1, 32'h0, 0, 0);
        xfer(2'd0, 32'h100, 32, 32'h0, 32'hDEAD_BEEF, 1, 1);
        xfer(2'd1, 32'h07, 8, 32'hA5, 32'h0, 2, 0);
        xfer(2'd0, 32'h02, 13, 32'h0, 32'h9876_5432, 3, 0);

        // Clock enable low: commands are not taken and a pending request freezes.
        cke_i       = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_mode_i  = 2'd1;
        cmd_addr_i  = 32'h11;
        cmd_width_i = 6'd8;
        cmd_data_i  = 32'h5A;
        repeat (2) @(negedge clk_i);
        check("cke_no_push", {busy_o, iob_valid_o}, 0);
        cke_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("cke_req", {iob_valid_o, iob_wstrb_o, iob_wdata_o}, {1'b1, 4'b0010, 32'h0000_5A00});
        cke_i       = 1'b0;
        iob_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("cke_hold", {iob_valid_o, rsp_valid_o}, 2'b10);
        cke_i = 1'b1;
        @(negedge clk_i);
        iob_ready_i = 1'b0;
        check("cke_resume", {iob_valid_o, rsp_valid_o, rsp_err_o}, 3'b010);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check("cke_done", busy_o, 0);

        // Timeout: slave never ready, limit 2**4-1 cycles.
        cmd_valid_i = 1'b1;
        cmd_mode_i  = 2'd1;
        cmd_addr_i  = 32'h20;
        cmd_width_i = 6'd32;
        cmd_data_i  = 32'h1357_9BDF;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        n = 0;
        for (int k = 0; k < 40 && iob_valid_o; k++) begin
            n++;
            @(negedge clk_i);
        end
        check("timeout_cycles", n, 15);
        check("timeout_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b11, 32'h0});
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk_i);
        iob_rvalid_i = 1'b0;
        check("timeout_late_rvalid", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b11, 32'h0});
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check("timeout_done", {rsp_valid_o, busy_o}, 0);

        // Reset while a request is offered.
        cmd_valid_i = 1'b1;
        cmd_mode_i  = 2'd0;
        cmd_addr_i  = 32'h10;
        cmd_width_i = 6'd32;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("rst_req_pre", iob_valid_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_req_post", {iob_valid_o, rsp_valid_o, busy_o, cmd_ready_o}, 4'b0001);

        // Reset while waiting for read data, with another command queued behind.
        cmd_valid_i = 1'b1;
        cmd_mode_i  = 2'd0;
        cmd_addr_i  = 32'h40;
        cmd_width_i = 6'd16;
        @(negedge clk_i);
        cmd_mode_i  = 2'd1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        check("wrd_req", iob_valid_o, 1);
        iob_ready_i = 1'b1;
        @(negedge clk_i);
        iob_ready_i = 1'b0;
        check("wrd_waiting", {iob_valid_o, rsp_valid_o, busy_o}, 3'b001);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("wrd_rst", {iob_valid_o, rsp_valid_o, busy_o, cmd_ready_o}, 4'b0001);
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'h1111_2222;
        @(negedge clk_i);
        iob_rvalid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("wrd_flushed", {iob_valid_o, rsp_valid_o, busy_o}, 0);

        // Fill the queue behind a held response, then drain in order.
        iob_ready_i  = 1'b1;
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = QRDATA;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (cmd_ready_o) begin
                rand_cmd(m, a, w, d);
                model(m, a, w, d, QRDATA, e_err, e_addr, e_strb, e_wdata, e_rsp);
                exp_q.push_back({e_err, e_rsp});
                cmd_valid_i = 1'b1;
                cmd_mode_i  = m;
                cmd_addr_i  = a;
                cmd_width_i = 6'(w);
                cmd_data_i  = d;
                n++;
            end else begin
                cmd_valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
        check("queue_accepted", n, 5);
        check("queue_full", {cmd_ready_o, busy_o, rsp_valid_o}, 3'b011);
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
            if (rsp_valid_o) begin
                exp_rsp = exp_q.pop_front();
                check("queue_rsp", {rsp_err_o, rsp_data_o}, exp_rsp);
            end
            @(negedge clk_i);
        end
        check("queue_drained", exp_q.size(), 0);
        rsp_ready_i  = 1'b0;
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("queue_idle", busy_o, 0);

        // Randomized single transfers with varying slave latency.
        for (int it = 0; it < 40; it++) begin
            rand_cmd(m, a, w, d);
            xfer(m, a, w, d, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
